// File: rtl/dm_stage_responder.sv
// dm_stage_responder: M-stage data-memory responder; latched request, fixed LATENCY, busy stall, registered response.
// Optional store trace: define DM_TRACE_EN to print every committed store.
module dm_stage_responder #(
    parameter int          ADDR_W    = 12,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_pc,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_n;
    logic [3:0] cnt;
    logic l_we;
    logic [31:0] l_addr, l_wdata, l_pc;
    logic [3:0] l_be;
    logic [31:0] mem [0:(1 << ADDR_W) - 1];
    logic idle, enter, err, c_we;
    logic [31:0] c_addr, c_wdata, c_pc, off, merged;
    logic [3:0] c_be;
    logic [ADDR_W-1:0] idx;
    // With LATENCY==1 the commit edge is the accept edge, so the live inputs are used there
    assign idle    = state == IDLE;
    assign c_we    = idle ? req_we : l_we;
    assign c_addr  = idle ? req_addr : l_addr;
    assign c_wdata = idle ? req_wdata : l_wdata;
    assign c_be    = idle ? req_be : l_be;
    assign c_pc    = idle ? req_pc : l_pc;
    assign off     = c_addr - BASE_ADDR;
    assign idx     = off[ADDR_W+1:2];
    assign err     = (c_addr[1:0] != 2'b00) || (c_addr < BASE_ADDR) || ((off >> (ADDR_W + 2)) != 32'd0);
    assign enter   = reset && (state_n == RESP);
    assign busy    = reset && ((idle && req_valid) || (state == WAIT));
    always_comb begin
        state_n = state;
        if (idle && req_valid)
            state_n = (LATENCY == 1) ? RESP : WAIT;
        else if (state == WAIT && cnt == 4'd1)
            state_n = RESP;
        else if (state == RESP)
            state_n = IDLE;
    end
    always_comb begin
        merged = mem[idx];
        for (int i = 0; i < 4; i++)
            if (c_be[i]) merged[8*i +: 8] = c_wdata[8*i +: 8];
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            l_we       <= 1'b0;
            l_addr     <= 32'd0;
            l_wdata    <= 32'd0;
            l_be       <= 4'd0;
            l_pc       <= 32'd0;
        end else begin
            state <= state_n;
            if (idle && req_valid) begin
                l_we    <= req_we;
                l_addr  <= req_addr;
                l_wdata <= req_wdata;
                l_be    <= req_be;
                l_pc    <= req_pc;
                cnt     <= 4'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            resp_valid <= enter;
            resp_err   <= enter && err;
            resp_rdata <= (enter && !c_we && !err) ? mem[idx] : 32'd0;
        end
    end
    always_ff @(posedge clk) begin
        if (enter && c_we && !err) begin
            mem[idx] <= merged;
`ifdef DM_TRACE_EN
            $display("%d@%h: *%h <= %h", $time, c_pc, c_addr, merged);
`endif
        end
    end
`ifndef DM_TRACE_EN
    logic unused_pc;
    assign unused_pc = ^c_pc;
`endif
endmodule

// File: tb/tb_dm_stage_responder.sv
// tb_dm_stage_responder: scoreboard bench over three responders with LATENCY 2, 4 and 1.
module tb_dm_stage_responder;
    localparam int LATS [3] = '{2, 4, 1};
    typedef struct {
        int          k;
        logic        err;
        logic [31:0] rd;
    } exp_t;
    exp_t sb [$];
    int passed = 0;
    int total = 0;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_valid [3];
    logic req_we [3];
    logic [31:0] req_addr [3];
    logic [31:0] req_wdata [3];
    logic [3:0] req_be [3];
    logic [31:0] req_pc [3];
    logic busy [3];
    logic resp_valid [3];
    logic [31:0] resp_rdata [3];
    logic resp_err [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dm_stage_responder #(.ADDR_W(12), .LATENCY(LATS[g]), .BASE_ADDR(32'h0000_0000)) u_dut (
            .clk(clk),
            .reset(reset),
            .req_valid(req_valid[g]),
            .req_we(req_we[g]),
            .req_addr(req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_be(req_be[g]),
            .req_pc(req_pc[g]),
            .busy(busy[g]),
            .resp_valid(resp_valid[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err(resp_err[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (resp_valid[k]) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_resp", 32'(k), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("resp_dut", 32'(k), 32'(e.k));
                    check("resp_err", {31'd0, resp_err[k]}, {31'd0, e.err});
                    check("resp_rdata", resp_rdata[k], e.rd);
                end
            end
        end
    end

    task automatic txn(input int k, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic e, input logic [31:0] rd);
        int n;
        sb.push_back('{k: k, err: e, rd: rd});
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = a;
        req_wdata[k] = d;
        req_be[k]    = be;
        req_pc[k]    = 32'h1000 + a;
        #1 check("busy_accept", {31'd0, busy[k]}, 32'd1);
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
        req_addr[k] = 32'hFFFF_FFFF;
        req_wdata[k] = 32'h0;
        n = 1;
        @(negedge clk);
        while (!resp_valid[k] && n < 20) begin
            check("busy_wait", {31'd0, busy[k]}, 32'd1);
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(LATS[k]));
        check("busy_resp", {31'd0, busy[k]}, 32'd0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b1;
            req_we[k]    = 1'b0;
            req_addr[k]  = 32'h10;
            req_wdata[k] = 32'h0;
            req_be[k]    = 4'h0;
            req_pc[k]    = 32'h0;
        end
        reset = 1'b0;
        // T1: reset held with requests pending
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                check("rst_busy", {31'd0, busy[k]}, 32'd0);
                check("rst_valid", {31'd0, resp_valid[k]}, 32'd0);
                check("rst_rdata", resp_rdata[k], 32'd0);
                check("rst_err", {31'd0, resp_err[k]}, 32'd0);
            end
        end
        for (int k = 0; k < 3; k++) req_valid[k] = 1'b0;
        reset = 1'b1;
        // T2: store then load, LATENCY 2
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);
        // T3: byte enables, and a store with no enables
        txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF, 1'b0, 32'h0);
        txn(0, 1'b1, 32'h20, 32'h11223344, 4'h3, 1'b0, 32'h0);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'hAABB3344);
        txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0);
        txn(0, 1'b1, 32'h24, 32'h99887766, 4'hC, 1'b0, 32'h0);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'hAABB3344);
        // T4: misaligned and out-of-range requests, top-word boundary
        txn(0, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0);
        txn(0, 1'b0, 32'h22, 32'h0, 4'h0, 1'b1, 32'h0);
        txn(0, 1'b1, 32'h4000, 32'h12345678, 4'hF, 1'b1, 32'h0);
        txn(0, 1'b1, 32'h13, 32'h12345678, 4'hF, 1'b1, 32'h0);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'hA5A5A5A5);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);
        txn(0, 1'b1, 32'h3FFC, 32'h0BADF00D, 4'hF, 1'b0, 32'h0);
        txn(0, 1'b0, 32'h3FFC, 32'h0, 4'h0, 1'b0, 32'h0BADF00D);
        txn(0, 1'b0, 32'h4000, 32'h0, 4'h0, 1'b1, 32'h0);
        txn(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 1'b1, 32'h0);
        // T5: reset during WAIT, LATENCY 4
        txn(1, 1'b1, 32'h0, 32'hCAFE0001, 4'hF, 1'b0, 32'h0);
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'h0;
        req_wdata[1] = 32'h5;
        req_be[1]    = 4'hF;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        check("t5_busy_wait", {31'd0, busy[1]}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) begin
            check("t5_no_valid", {31'd0, resp_valid[1]}, 32'd0);
            check("t5_busy_idle", {31'd0, busy[1]}, 32'd0);
            @(negedge clk);
        end
        txn(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'hCAFE0001);
        // T6: back-to-back loads, LATENCY 1
        txn(2, 1'b1, 32'h40, 32'h40404040, 4'hF, 1'b0, 32'h0);
        txn(2, 1'b1, 32'h44, 32'h44444444, 4'hF, 1'b0, 32'h0);
        txn(2, 1'b1, 32'h48, 32'h48484848, 4'hF, 1'b0, 32'h0);
        sb.push_back('{k: 2, err: 1'b0, rd: 32'h40404040});
        sb.push_back('{k: 2, err: 1'b0, rd: 32'h44444444});
        sb.push_back('{k: 2, err: 1'b0, rd: 32'h48484848});
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b0;
        req_addr[2]  = 32'h40;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("t6_busy", {31'd0, busy[2]}, (c % 2 == 0) ? 32'd1 : 32'd0);
            check("t6_valid", {31'd0, resp_valid[2]}, (c % 2 == 1) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
            if (c == 4) req_valid[2] = 1'b0;
            if (c == 0) req_addr[2] = 32'h44;
            if (c == 2) req_addr[2] = 32'h48;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
